// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One transaction takes three cycles: IDLE (sample), ACCESS (drive memory), RESP (return).
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              mem_write_en,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              ptr;        // port favoured when both request
  logic              win;        // latched winner id
  logic              win_nxt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              in_range;
  logic              any_req;

  assign in_range = (lat_addr[31:ADDR_W] == '0);
  assign any_req  = req0 | req1;

  assign mem_addr       = {{(32-ADDR_W){1'b0}}, lat_addr[ADDR_W-1:0]};
  assign mem_write_data = lat_wdata;

  // State register, arbitration pointer, request latch and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        win       <= win_nxt;
        ptr       <= ~win_nxt;
        lat_we    <= win_nxt ? we1 : we0;
        lat_addr  <= win_nxt ? addr1 : addr0;
        lat_wdata <= win_nxt ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        rdata_q <= (!lat_we && in_range) ? mem_read_data : '0;
        err_q   <= !in_range;
      end
    end
  end

  // Next-state, winner selection and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    win_nxt      = req1 & (~req0 | ptr);
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    rvalid0      = 1'b0;
    rvalid1      = 1'b0;
    rdata0       = '0;
    rdata1       = '0;
    err0         = 1'b0;
    err1         = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt    = RESP;
        gnt0         = ~win;
        gnt1         = win;
        mem_write_en = lat_we & in_range;
      end
      RESP: begin
        state_nxt = IDLE;
        rvalid0   = ~win;
        rvalid1   = win;
        if (win) begin
          rdata1 = rdata_q;
          err1   = err_q;
        end else begin
          rdata0 = rdata_q;
          err0   = err_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port round-robin arbiter that shares the single-port, 1024-word data memory between two requesters, such as the CPU load/store unit (port 0) and a loader/I/O master (port 1). The arbiter registers one winning request, drives the memory for exactly one cycle, and returns registered read data with a one-cycle valid pulse. It sits between the requesters and the data memory; the memory's write port and combinational read port connect only to this block.

## Interface
- ADDR_W, 10: number of word-address bits implemented by the memory (depth = 2**ADDR_W).
- DATA_W, 32: data word width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reqN  in  1  request from port N (N = 0, 1); held high with weN/addrN/wdataN stable until gntN is seen.
- weN  in  1  1 = write, 0 = read.
- addrN  in  32  word address.
- wdataN  in  DATA_W  write data.
- gntN  out  1  high during the single cycle in which port N's access is driven on the memory.
- rvalidN  out  1  one-cycle pulse; rdataN/errN are valid in this cycle. Pulses for writes too, as completion.
- rdataN  out  DATA_W  read data. 0 for writes and for errored accesses.
- errN  out  1  qualified by rvalidN; the address was out of range.
- mem_write_en  out  1  memory write enable.
- mem_addr  out  32  memory address, zero-extended from ADDR_W bits.
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  combinational memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: requests are sampled only in this state.
  - No request: stay in IDLE.
  - Any request: latch the winner id, we, addr and wdata, then go to ACCESS.
- Arbitration uses a one-bit priority pointer, reset to 0.
  - Single request: that port wins.
  - Both ports requesting: the port named by the pointer wins.
  - After every grant, the pointer moves to the other port.
- ACCESS:
  - gnt of the winner = 1.
  - mem_addr = latched addr[ADDR_W-1:0].
  - mem_write_data = latched wdata.
  - mem_write_en = latched we AND in_range.
  - At the end of the cycle, capture rdata = (read AND in_range) ? mem_read_data : 0, and capture err = !in_range. Go to RESP.
- in_range: addr[31:ADDR_W] == 0. Out-of-range writes are dropped; memory contents are not modified.
- RESP: rvalid, rdata and err of the winner are driven from registers. Next state is always IDLE.
- Outside ACCESS:
  - mem_write_en = 0.
  - mem_addr and mem_write_data hold their last latched value. Reset value is 0.
- A requester that keeps req high after its gnt cycle issues a new transaction, sampled at the next IDLE edge.
- Reset (asynchronous, may arrive mid-transaction):
  - state = IDLE, pointer = 0, latched fields = 0.
  - All gnt, rvalid, err, rdata and mem_write_en outputs = 0 immediately.
  - An in-flight write not yet committed at a clock edge is lost.

## Timing
- Request-to-grant latency: req high at edge E0 in IDLE; gnt is high during E0–E1.
- Write commit: the memory commits the write at E1.
- Response: rvalid and rdata are high during E1–E2. State is IDLE again at E2, where the next request is sampled.
- Throughput: one transaction per 3 cycles in total, across both ports.
- Read-after-write: a read granted after a write to the same address returns the new data. The write commits at E1, before any later ACCESS cycle.
- Sustained contention: with both reqs held high, grants alternate 0,1,0,1… starting with port 0 after reset. Maximum wait for any port is one transaction (3 cycles).
- All outputs are registered or decoded from FSM state. The only combinational path from an input to an output is mem_read_data to the rdata capture register, with no direct path to an output.

## Test plan
- Reset then single read: port 0 reads addr 5 with the memory at reset contents. Required: gnt0 at cycle 1, rvalid0 at cycle 2, rdata0 = 0x0000000A, err0 = 0.
- Write then read: port 1 writes 0xDEADBEEF to addr 1023, then reads addr 1023. Required: mem_write_en high for exactly one cycle with mem_addr = 1023; the read returns 0xDEADBEEF.
- Contention: both ports hold req (reads of addr 3 and addr 4) for 12 cycles. Required: grant order 0,1,0,1; each rdata matches its own address; gnt0 and gnt1 are never high together.
- Out of range: port 0 writes 0x12345678 to addr 1024. Required: mem_write_en stays 0; rvalid0 with err0 = 1 and rdata0 = 0. A following read of addr 0 returns 0x0000000A (no aliasing).
- Reset mid-ACCESS: assert rst while gnt1 is high for a write of 0x55 to addr 7. Required: gnt1 and mem_write_en drop immediately; no rvalid1; after reset the pointer = 0 and a read of addr 7 returns 0x0000000A.
- Back-to-back same port: port 0 holds req high across 3 transactions. Required: gnt0 every third cycle and rvalid0 after each grant; port 1 is never granted.
